sc_regbus_arb: RTL and testbench
================================

Name: sc_regbus_arb

Overview:
- Two-requester arbiter for the Space Cubics register bus. Two bus-IP masters (m0, m1) share one register slave (s).
- Write and read channels are arbitrated independently, each with a round-robin state machine. Either channel may serve m0 while the other serves m1.
- An optional per-channel watchdog terminates a slave that stalls for too long.
- Sits between bus-bridge IPs (e.g. an AXI bridge plus a debug/SPI host) and a shared register block.

Parameters:
- TOUT, 0, watchdog limit in stalled cycles per transaction. 0 disables the watchdog. Legal range 0..65535.

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- m0  interface  sc_regbus_if.regif  requester 0; arbiter acts as its register slave.
- m1  interface  sc_regbus_if.regif  requester 1.
- s  interface  sc_regbus_if.busip  shared downstream slave; arbiter acts as its bus master.

Behaviour:
- Request definition: master x requests the write channel when mx.WENB != 0, and the read channel when mx.RENB != 0.
- Master obligations: a requesting master holds ADR/TYP/ENB/DAT stable until it sees WWAT/RWAT = 0.
- Completion: a transfer completes in a cycle where its channel is granted to x, x requests, and s.WWAT (or s.RWAT) = 0.
- Per-channel FSM states: IDLE, GNT0, GNT1. Each channel also holds a last-grant pointer LG and a watchdog counter CNT (16 bits, saturating). Description below is for the write channel; the read channel is identical using R* signals.
- Reset: state IDLE, LG = 1 (m0 wins the first tie), CNT = 0.
- Slave-side outputs:
  - In IDLE: s.WADR, s.WTYP, s.WENB, s.WDAT are all 0.
  - In GNTx: these are driven by mx's signals, combinationally from the registered state.
  - Consequence: zero at reset.
- Master-side outputs:
  - Granted master: mx.WWAT = s.WWAT, mx.WERR = s.WERR.
  - Non-granted master: WWAT = 1 if requesting else 0; WERR = 0.
  - Read channel: non-granted mx.RDAT = 0; granted mx.RDAT = s.RDAT.
  - Consequence at reset: WWAT mirrors the own request, WERR = 0, RDAT = 0.
- IDLE transitions:
  - Only m0 requests -> GNT0 next cycle.
  - Only m1 requests -> GNT1.
  - Both request -> GNT of the master != LG.
  - Arbitration latency is 1 cycle: the request is seen in IDLE and the slave sees it in the following cycle.
- GNTx transitions:
  - Completion -> LG <= x. Next state is GNT(other) if the other master requests in that cycle, otherwise IDLE.
  - Result: back-to-back alternation with no idle bubble. The same master can never be granted twice in a row while the other waits.
  - mx drops its ENB while still granted (protocol violation) -> IDLE next cycle, LG <= x, no error reported.
- Watchdog (TOUT > 0):
  - CNT increments each GNTx cycle with s.WWAT = 1, and clears on any state change.
  - When CNT == TOUT and s.WWAT = 1, the arbiter forces mx.WWAT = 0 and mx.WERR = 1 for that cycle (terminate).
  - It then transitions exactly as on a normal completion.
  - A late completion by the slave is not forwarded. When TOUT = 0, CNT is unused and no forced termination occurs.
- Channels are fully independent. Simultaneous write grant to m0 and read grant to m1 is legal.
- Async reset mid-transfer:
  - Immediately returns to IDLE and forces all s.* request outputs to 0.
  - The interrupted master sees WWAT = 1 (if still requesting) and is re-arbitrated after RSTN rises.

Test Plan:
- m0 write WADR=0x10, WDAT=0xA5A5A5A5, WENB=0xF. Slave WWAT=1 for 2 cycles -> s.WENB=0xF from cycle 1; m0.WWAT low in cycle 3; s.WENB=0 in cycle 4.
- m0 and m1 both write in the same cycle after reset -> m0 granted first. m1 is granted in the cycle right after m0's completion with no IDLE bubble. LG=1 afterward.
- m0 issues 3 back-to-back writes while m1 holds one pending write -> grant order m0, m1, m0, m0. m1 sees WWAT=1 and WERR=0 while waiting.
- m0 write concurrent with m1 read RADR=0x20, slave RDAT=0x12345678 -> both proceed in parallel. m1.RDAT=0x12345678 at completion; m0.RDAT=0 throughout.
- TOUT=4, slave holds RWAT=1 forever on an m1 read -> m1 sees RWAT=0, RERR=1 on the 5th granted cycle. Channel returns to IDLE and then serves a pending m0 read.
- RSTN asserted during m1 GNT1 with s.WWAT=1 -> s.WENB=0 asynchronously. After release, m1's held request is re-granted one cycle later.

Source files
------------

// File: rtl/sc_regbus_if.sv
// Space Cubics register bus bundle.
//
// One instance carries both channels of a single register-bus link:
//   write channel : WADR/WTYP/WENB/WDAT from the bus IP, WWAT/WERR back
//   read channel  : RADR/RTYP/RENB from the bus IP, RDAT/RWAT/RERR back
//
// Modports:
//   busip : the side that issues transfers (drives ADR/TYP/ENB/DAT)
//   regif : the side that serves transfers (drives WAT/ERR/RDAT)
interface sc_regbus_if;
    logic [15:0] WADR;
    logic [2:0]  WTYP;
    logic [3:0]  WENB;
    logic [31:0] WDAT;
    logic        WWAT;
    logic        WERR;

    logic [15:0] RADR;
    logic [2:0]  RTYP;
    logic [3:0]  RENB;
    logic [31:0] RDAT;
    logic        RWAT;
    logic        RERR;

    modport busip (
        output WADR, WTYP, WENB, WDAT, RADR, RTYP, RENB,
        input  WWAT, WERR, RDAT, RWAT, RERR
    );

    modport regif (
        input  WADR, WTYP, WENB, WDAT, RADR, RTYP, RENB,
        output WWAT, WERR, RDAT, RWAT, RERR
    );
endinterface

// File: rtl/sc_regbus_arb.sv
// Two-requester round-robin arbiter for the Space Cubics register bus.
//
// Two bus-IP masters (m0, m1) share one register slave (s). The write and
// read channels are arbitrated independently, so one channel may serve m0
// while the other serves m1. An optional per-channel watchdog terminates a
// slave that stalls for TOUT cycles (TOUT = 0 disables it).
//
// Ports:
//   CLK  : clock, all state on the rising edge
//   RSTN : asynchronous active-low reset
//   m0   : requester 0 (arbiter is its register slave)
//   m1   : requester 1
//   s    : shared downstream slave (arbiter is its bus master)

// One arbitration channel: round-robin FSM, last-grant pointer and watchdog.
module sc_regbus_arb_ch #(
    parameter int unsigned TOUT = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic s_wat,
    input  logic s_err,
    output logic gnt0,
    output logic gnt1,
    output logic wat0,
    output logic err0,
    output logic wat1,
    output logic err1
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] TOUT_L  = 16'(TOUT);
    localparam bit          WDOG_EN = (TOUT != 0);

    state_t      state_q, state_d;
    logic        lg_q, lg_d;
    logic [15:0] cnt_q, cnt_d;
    logic        own_req, oth_req, tmo, done;

    // A watchdog termination looks like a completion to the FSM but is
    // reported to the master as an error; any late slave response is hidden.
    always_comb begin
        gnt0    = (state_q == GNT0);
        gnt1    = (state_q == GNT1);
        own_req = (gnt0 & req0) | (gnt1 & req1);
        oth_req = (gnt0 & req1) | (gnt1 & req0);
        tmo     = WDOG_EN && own_req && s_wat && (cnt_q == TOUT_L);
        done    = own_req && (!s_wat || tmo);
        wat0    = gnt0 ? (s_wat & ~tmo) : req0;
        err0    = gnt0 ? (s_err | tmo)  : 1'b0;
        wat1    = gnt1 ? (s_wat & ~tmo) : req1;
        err1    = gnt1 ? (s_err | tmo)  : 1'b0;
    end

    // On completion the other master is granted straight away if it is
    // waiting, so two busy masters alternate without an idle bubble.
    always_comb begin
        state_d = state_q;
        lg_d    = lg_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || lg_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                if (!own_req || done) begin
                    lg_d    = (state_q == GNT1);
                    state_d = (done && oth_req) ? ((state_q == GNT0) ? GNT1 : GNT0) : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!WDOG_EN || (state_d != state_q)) begin
            cnt_d = '0;
        end else if ((gnt0 || gnt1) && s_wat && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // LG resets to 1 so that m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lg_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lg_q    <= lg_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

module sc_regbus_arb #(
    parameter int unsigned TOUT = 0
) (
    input  logic        CLK,
    input  logic        RSTN,
    sc_regbus_if.regif  m0,
    sc_regbus_if.regif  m1,
    sc_regbus_if.busip  s
);
    logic w_gnt0, w_gnt1, w_wat0, w_err0, w_wat1, w_err1;
    logic r_gnt0, r_gnt1, r_wat0, r_err0, r_wat1, r_err1;

    sc_regbus_arb_ch #(.TOUT(TOUT)) u_wch (
        .clk   (CLK),
        .rst_n (RSTN),
        .req0  (m0.WENB != 4'h0),
        .req1  (m1.WENB != 4'h0),
        .s_wat (s.WWAT),
        .s_err (s.WERR),
        .gnt0  (w_gnt0),
        .gnt1  (w_gnt1),
        .wat0  (w_wat0),
        .err0  (w_err0),
        .wat1  (w_wat1),
        .err1  (w_err1)
    );

    sc_regbus_arb_ch #(.TOUT(TOUT)) u_rch (
        .clk   (CLK),
        .rst_n (RSTN),
        .req0  (m0.RENB != 4'h0),
        .req1  (m1.RENB != 4'h0),
        .s_wat (s.RWAT),
        .s_err (s.RERR),
        .gnt0  (r_gnt0),
        .gnt1  (r_gnt1),
        .wat0  (r_wat0),
        .err0  (r_err0),
        .wat1  (r_wat1),
        .err1  (r_err1)
    );

    assign m0.WWAT = w_wat0;
    assign m0.WERR = w_err0;
    assign m1.WWAT = w_wat1;
    assign m1.WERR = w_err1;
    assign m0.RWAT = r_wat0;
    assign m0.RERR = r_err0;
    assign m1.RWAT = r_wat1;
    assign m1.RERR = r_err1;

    // Slave requests come only from the registered grant, so an idle or
    // reset channel presents all-zero signals to the slave.
    always_comb begin
        s.WADR = '0;
        s.WTYP = '0;
        s.WENB = '0;
        s.WDAT = '0;
        if (w_gnt0) begin
            s.WADR = m0.WADR;
            s.WTYP = m0.WTYP;
            s.WENB = m0.WENB;
            s.WDAT = m0.WDAT;
        end else if (w_gnt1) begin
            s.WADR = m1.WADR;
            s.WTYP = m1.WTYP;
            s.WENB = m1.WENB;
            s.WDAT = m1.WDAT;
        end

        s.RADR = '0;
        s.RTYP = '0;
        s.RENB = '0;
        if (r_gnt0) begin
            s.RADR = m0.RADR;
            s.RTYP = m0.RTYP;
            s.RENB = m0.RENB;
        end else if (r_gnt1) begin
            s.RADR = m1.RADR;
            s.RTYP = m1.RTYP;
            s.RENB = m1.RENB;
        end

        m0.RDAT = r_gnt0 ? s.RDAT : '0;
        m1.RDAT = r_gnt1 ? s.RDAT : '0;
    end
endmodule

// File: tb/tb_sc_regbus_arb.sv
// Testbench for sc_regbus_arb (TOUT = 4).
//
// Each master keeps a queue of transfers per channel. The head of the queue
// is driven until the expected WAT reads 0, then popped. Expected outputs
// come from a small per-channel behavioural model (owner, last winner,
// stall count) kept here. Directed scenarios come first, then random traffic.
module tb_sc_regbus_arb;
    localparam int TOUT = 4;

    typedef struct packed {
        logic [15:0] adr;
        logic [2:0]  typ;
        logic [3:0]  enb;
        logic [31:0] dat;
    } txn_t;

    logic CLK  = 1'b0;
    logic RSTN = 1'b0;

    sc_regbus_if im0();
    sc_regbus_if im1();
    sc_regbus_if is();

    sc_regbus_arb #(.TOUT(TOUT)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .m0   (im0),
        .m1   (im1),
        .s    (is)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    txn_t        tq [4][$];
    txn_t        cur [2][2];
    logic        s_wat [2];
    logic        s_err [2];
    logic [31:0] s_rdat;
    int          owner [2];
    int          last [2];
    int          stall [2];
    bit          done_seen [2][2];
    int          wr_grants [$];
    bit          rand_mode;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic [15:0] adr, input logic [2:0] typ,
                                input logic [3:0] enb, input logic [31:0] dat);
        txn_t t;
        t.adr = adr;
        t.typ = typ;
        t.enb = enb;
        t.dat = dat;
        return t;
    endfunction

    function automatic bit req(input int m, input int c);
        return cur[m][c].enb != 4'h0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            owner[c] = -1;
            last[c]  = 1;
            stall[c] = 0;
        end
    endtask

    // Load queue heads into the master signals and copy slave responses.
    task automatic applyStimulus();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < 2; c++)
                cur[m][c] = (tq[m*2+c].size() > 0) ? tq[m*2+c][0] : '0;
        im0.WADR = cur[0][0].adr; im0.WTYP = cur[0][0].typ;
        im0.WENB = cur[0][0].enb; im0.WDAT = cur[0][0].dat;
        im0.RADR = cur[0][1].adr; im0.RTYP = cur[0][1].typ; im0.RENB = cur[0][1].enb;
        im1.WADR = cur[1][0].adr; im1.WTYP = cur[1][0].typ;
        im1.WENB = cur[1][0].enb; im1.WDAT = cur[1][0].dat;
        im1.RADR = cur[1][1].adr; im1.RTYP = cur[1][1].typ; im1.RENB = cur[1][1].enb;
        is.WWAT = s_wat[0]; is.WERR = s_err[0];
        is.RWAT = s_wat[1]; is.RERR = s_err[1];
        is.RDAT = s_rdat;
    endtask

    // Compare every DUT output against what the model predicts right now.
    task automatic check_now();
        logic        act_wat [2][2];
        logic        act_err [2][2];
        logic [31:0] act_rdat [2];
        txn_t        et;
        int          x;
        bit          own, tmo;
        logic        ew, ee;
        act_wat[0][0] = im0.WWAT; act_wat[0][1] = im0.RWAT;
        act_wat[1][0] = im1.WWAT; act_wat[1][1] = im1.RWAT;
        act_err[0][0] = im0.WERR; act_err[0][1] = im0.RERR;
        act_err[1][0] = im1.WERR; act_err[1][1] = im1.RERR;
        act_rdat[0] = im0.RDAT;   act_rdat[1] = im1.RDAT;
        for (int c = 0; c < 2; c++) begin
            x   = owner[c];
            own = (x >= 0) ? req(x, c) : 1'b0;
            tmo = own && s_wat[c] && (stall[c] == TOUT);
            et  = (x >= 0) ? cur[x][c] : '0;
            for (int m = 0; m < 2; m++) begin
                ew = (x == m) ? (tmo ? 1'b0 : s_wat[c]) : req(m, c);
                ee = (x == m) ? (tmo ? 1'b1 : s_err[c]) : 1'b0;
                done_seen[m][c] = req(m, c) && !ew;
                checkOutput($sformatf("m%0d.%sWAT", m, (c == 0) ? "W" : "R"), act_wat[m][c], ew);
                checkOutput($sformatf("m%0d.%sERR", m, (c == 0) ? "W" : "R"), act_err[m][c], ee);
                if (c == 1)
                    checkOutput($sformatf("m%0d.RDAT", m), act_rdat[m], (x == m) ? s_rdat : 32'h0);
            end
            if (c == 0) begin
                checkOutput("s.WENB", is.WENB, et.enb);
                checkOutput("s.WADR", is.WADR, et.adr);
                checkOutput("s.WTYP", is.WTYP, et.typ);
                checkOutput("s.WDAT", is.WDAT, et.dat);
            end else begin
                checkOutput("s.RENB", is.RENB, et.enb);
                checkOutput("s.RADR", is.RADR, et.adr);
                checkOutput("s.RTYP", is.RTYP, et.typ);
            end
        end
    endtask

    task automatic sample();
        @(negedge CLK);
        check_now();
    endtask

    // Round-robin rules: tie goes to the master that did not win last;
    // after a finished (or timed-out) transfer the waiting master goes next.
    task automatic model_step();
        int x;
        bit own, tmo;
        for (int c = 0; c < 2; c++) begin
            x = owner[c];
            if (x < 0) begin
                if (req(0, c) && req(1, c)) owner[c] = (last[c] == 1) ? 0 : 1;
                else if (req(0, c))         owner[c] = 0;
                else if (req(1, c))         owner[c] = 1;
                if (owner[c] >= 0 && c == 0) wr_grants.push_back(owner[c]);
                stall[c] = 0;
            end else begin
                own = req(x, c);
                tmo = own && s_wat[c] && (stall[c] == TOUT);
                if (!own || !s_wat[c] || tmo) begin
                    last[c]  = x;
                    owner[c] = -1;
                    stall[c] = 0;
                    if (own && req(1 - x, c)) begin
                        owner[c] = 1 - x;
                        if (c == 0) wr_grants.push_back(owner[c]);
                    end
                end else if (stall[c] < 65535) begin
                    stall[c]++;
                end
            end
        end
    endtask

    task automatic agent_update();
        int idx;
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 2; c++) begin
                idx = m * 2 + c;
                if (done_seen[m][c] && tq[idx].size() > 0)
                    tq[idx].delete(0);
                else if (rand_mode && owner[c] == m && tq[idx].size() > 0 && $urandom_range(0, 63) == 0)
                    tq[idx].delete(0);
                if (rand_mode && tq[idx].size() == 0 && $urandom_range(0, 2) == 0)
                    tq[idx].push_back(mk(16'($urandom), 3'($urandom), 4'($urandom_range(1, 15)), $urandom));
                done_seen[m][c] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int c = 0; c < 2; c++) begin
                s_wat[c] = ($urandom_range(0, 99) < 55);
                s_err[c] = ($urandom_range(0, 7) == 0);
            end
            s_rdat = $urandom;
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        if (RSTN) model_step();
        #1;
        agent_update();
        applyStimulus();
    endtask

    task automatic reset_dut();
        RSTN = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) tq[i].delete();
        wr_grants.delete();
        for (int c = 0; c < 2; c++) begin
            s_wat[c] = 1'b0;
            s_err[c] = 1'b0;
            for (int m = 0; m < 2; m++) done_seen[m][c] = 1'b0;
        end
        s_rdat    = 32'h0;
        rand_mode = 1'b0;
        applyStimulus();
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
    endtask

    initial begin
        int exp_order [4];
        exp_order = '{0, 1, 0, 0};

        // Reset state
        reset_dut();
        sample();
        checkOutput("rst s.WENB", is.WENB, 32'h0);
        checkOutput("rst s.RENB", is.RENB, 32'h0);
        checkOutput("rst m0.WERR", im0.WERR, 32'h0);
        checkOutput("rst m1.RDAT", im1.RDAT, 32'h0);
        advance();

        // Single m0 write with a two-cycle slave stall
        $display("[TB] single write with stall");
        reset_dut();
        tq[0].push_back(mk(16'h0010, 3'd0, 4'hF, 32'hA5A5A5A5));
        s_wat[0] = 1'b1;
        applyStimulus();
        sample();
        checkOutput("t1 c0 s.WENB", is.WENB, 32'h0);
        checkOutput("t1 c0 m0.WWAT", im0.WWAT, 32'h1);
        advance();
        sample();
        checkOutput("t1 c1 s.WENB", is.WENB, 32'hF);
        checkOutput("t1 c1 s.WDAT", is.WDAT, 32'hA5A5A5A5);
        advance();
        sample();
        advance();
        s_wat[0] = 1'b0;
        applyStimulus();
        sample();
        checkOutput("t1 c3 m0.WWAT", im0.WWAT, 32'h0);
        advance();
        sample();
        checkOutput("t1 c4 s.WENB", is.WENB, 32'h0);
        advance();

        // Simultaneous requests: m0 first, m1 with no bubble, then m0 wins again
        $display("[TB] simultaneous writes");
        reset_dut();
        tq[0].push_back(mk(16'h0100, 3'd1, 4'h3, 32'h11111111));
        tq[2].push_back(mk(16'h0200, 3'd2, 4'hC, 32'h22222222));
        applyStimulus();
        sample();
        advance();
        sample();
        checkOutput("t2 c1 s.WADR", is.WADR, 32'h0100);
        advance();
        sample();
        checkOutput("t2 c2 s.WADR", is.WADR, 32'h0200);
        tq[0].push_back(mk(16'h0101, 3'd1, 4'h1, 32'h33333333));
        tq[2].push_back(mk(16'h0201, 3'd1, 4'h1, 32'h44444444));
        advance();
        sample();
        checkOutput("t2 c3 s.WENB", is.WENB, 32'h0);
        advance();
        sample();
        checkOutput("t2 c4 s.WADR", is.WADR, 32'h0101);
        repeat (3) begin advance(); sample(); end
        advance();

        // Three back-to-back m0 writes against one pending m1 write
        $display("[TB] round-robin order");
        reset_dut();
        for (int i = 0; i < 3; i++) tq[0].push_back(mk(16'h0030 + 16'(i), 3'd0, 4'hF, 32'(i)));
        tq[2].push_back(mk(16'h0040, 3'd0, 4'h5, 32'hBEEF0000));
        applyStimulus();
        for (int i = 0; i < 14; i++) begin
            s_wat[0] = i[0];
            applyStimulus();
            sample();
            advance();
        end
        checkOutput("t3 grant count", wr_grants.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < wr_grants.size())
                checkOutput($sformatf("t3 grant %0d", i), wr_grants[i], exp_order[i]);

        // Write and read in parallel for different masters
        $display("[TB] parallel channels");
        reset_dut();
        tq[0].push_back(mk(16'h0050, 3'd0, 4'hF, 32'hCAFEF00D));
        tq[3].push_back(mk(16'h0020, 3'd0, 4'hF, 32'h0));
        s_rdat = 32'h12345678;
        applyStimulus();
        sample();
        advance();
        sample();
        checkOutput("t4 m1.RDAT", im1.RDAT, 32'h12345678);
        checkOutput("t4 m0.RDAT", im0.RDAT, 32'h0);
        checkOutput("t4 s.WENB", is.WENB, 32'hF);
        checkOutput("t4 s.RADR", is.RADR, 32'h0020);
        advance();
        sample();
        advance();

        // Watchdog on a read that never completes
        $display("[TB] read watchdog");
        reset_dut();
        tq[3].push_back(mk(16'h0060, 3'd0, 4'hF, 32'h0));
        s_wat[1] = 1'b1;
        applyStimulus();
        for (int k = 0; k < 6; k++) begin
            sample();
            if (k == 4) checkOutput("t5 c4 m1.RWAT", im1.RWAT, 32'h1);
            if (k == 5) begin
                checkOutput("t5 c5 m1.RWAT", im1.RWAT, 32'h0);
                checkOutput("t5 c5 m1.RERR", im1.RERR, 32'h1);
            end
            advance();
        end
        tq[1].push_back(mk(16'h0070, 3'd0, 4'h7, 32'h0));
        applyStimulus();
        sample();
        checkOutput("t5 c6 s.RENB", is.RENB, 32'h0);
        advance();
        sample();
        checkOutput("t5 c7 s.RADR", is.RADR, 32'h0070);
        repeat (6) begin advance(); sample(); end
        advance();

        // Asynchronous reset in the middle of an m1 write
        $display("[TB] reset mid-transfer");
        reset_dut();
        tq[2].push_back(mk(16'h0080, 3'd0, 4'h3, 32'h55AA55AA));
        s_wat[0] = 1'b1;
        applyStimulus();
        sample();
        advance();
        sample();
        checkOutput("t6 granted s.WENB", is.WENB, 32'h3);
        #2 RSTN = 1'b0;
        model_reset();
        #1;
        check_now();
        checkOutput("t6 in reset s.WENB", is.WENB, 32'h0);
        checkOutput("t6 in reset m1.WWAT", im1.WWAT, 32'h1);
        advance();
        RSTN = 1'b1;
        sample();
        checkOutput("t6 released s.WENB", is.WENB, 32'h0);
        advance();
        sample();
        checkOutput("t6 regrant s.WENB", is.WENB, 32'h3);
        s_wat[0] = 1'b0;
        applyStimulus();
        repeat (3) begin advance(); sample(); end
        advance();

        // Random traffic on both channels
        $display("[TB] random traffic");
        reset_dut();
        rand_mode = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            sample();
            advance();
        end
        rand_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
